// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the LED matrix column scanner and row driver.
// Column-to-group mirroring lives here so both sides agree on the mapping.
package matrix_pkg;

  localparam int DEFAULT_COLS = 5;

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } scan_state_e;

  function automatic int groups_f(input int cols);
    return (cols + 1) / 2;
  endfunction

  // Never returns less than 1 so a two-entry range still gets a real bit.
  function automatic int clog2_f(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int mirror_f(input int p, input int cols);
    return (p < (cols - 1 - p)) ? p : (cols - 1 - p);
  endfunction

endpackage

// File: rtl/matrix_column_scanner_if.sv
// Scanner-to-row-driver bundle: run/pause control in, column drive and strobes out.
interface matrix_column_scanner_if
  import matrix_pkg::*;
#(
  parameter int COLS = DEFAULT_COLS
);

  localparam int GROUPS = groups_f(COLS);
  localparam int IDX_W  = clog2_f(COLS);

  logic              enable;
  logic [COLS-1:0]   col_onehot;
  logic [GROUPS-1:0] col_group;
  logic [IDX_W-1:0]  col_index;
  logic              row_load;
  logic              frame_start;

  modport master (
    input  enable,
    output col_onehot,
    output col_group,
    output col_index,
    output row_load,
    output frame_start
  );

  modport slave (
    output enable,
    input  col_onehot,
    input  col_group,
    input  col_index,
    input  row_load,
    input  frame_start
  );

endinterface

// File: rtl/matrix_dwell_timer.sv
// Counts 0..DWELL-1 within one column; clear wins over hold, wrap is explicit.
module matrix_dwell_timer
  import matrix_pkg::*;
#(
  parameter int DWELL = 4,
  localparam int W    = clog2_f(DWELL)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc    = (count_q == W'(DWELL - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/matrix_column_scanner.sv
// Column scan driver: walks pos through COLS columns, blanking the first BLANK
// clocks of each DWELL-clock column; all outputs are decoded from registers only.
module matrix_column_scanner
  import matrix_pkg::*;
#(
  parameter int COLS       = DEFAULT_COLS,
  parameter int DWELL      = 4,
  parameter int BLANK      = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  matrix_column_scanner_if.master bus
);

  localparam int GROUPS = groups_f(COLS);
  localparam int IDX_W  = clog2_f(COLS);
  localparam int DW_W   = clog2_f(DWELL);

  scan_state_e       state_q;
  scan_state_e       state_d;
  logic [IDX_W-1:0]  pos_q;
  logic [IDX_W-1:0]  pos_d;
  logic [DW_W-1:0]   dwell;
  logic              dwell_tc;
  logic              dwell_clear;
  logic              dwell_hold;

  matrix_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clock (clock),
    .reset (reset),
    .clear (dwell_clear),
    .hold  (dwell_hold),
    .count (dwell),
    .tc    (dwell_tc)
  );

  // Resuming from pause restarts the column at its blank phase, keeping pos.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dwell_clear = 1'b0;
    dwell_hold  = 1'b1;
    case (state_q)
      ST_PAUSED: begin
        if (bus.enable) begin
          state_d     = ST_RUN;
          dwell_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.enable) begin
          state_d = ST_PAUSED;
        end else begin
          dwell_hold = 1'b0;
          if (dwell_tc) begin
            pos_d = (pos_q == IDX_W'(COLS - 1)) ? '0 : pos_q + 1'b1;
          end
        end
      end
      default: state_d = ST_PAUSED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_PAUSED;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  logic              running;
  logic              drive_on;
  logic [COLS-1:0]   onehot_raw;
  logic [GROUPS-1:0] group_raw;
  int                grp_idx;

  assign running  = (state_q == ST_RUN);
  assign drive_on = running && (dwell >= DW_W'(BLANK));
  assign grp_idx  = mirror_f(int'(pos_q), COLS);

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign onehot_raw[gi] = drive_on && (pos_q == IDX_W'(gi));
    end
    for (gi = 0; gi < GROUPS; gi++) begin : g_grp
      assign group_raw[gi] = drive_on && (grp_idx == gi);
    end
  endgenerate

  assign bus.col_onehot  = (ACTIVE_LOW != 0) ? ~onehot_raw : onehot_raw;
  assign bus.col_group   = (ACTIVE_LOW != 0) ? ~group_raw : group_raw;
  assign bus.col_index   = pos_q;
  assign bus.row_load    = running && (dwell == '0);
  assign bus.frame_start = running && (dwell == '0) && (pos_q == '0);

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Directed and randomised checks of the column scanner in two configurations.
module tb_matrix_column_scanner;

  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;
  int   checks = 0;
  int   errors = 0;

  int oh_a  [5] = '{1, 2, 4, 8, 16};
  int grp_a [5] = '{1, 2, 4, 2, 1};
  int oh_b  [4] = '{14, 13, 11, 7};
  int grp_b [4] = '{2, 1, 1, 2};

  always #5 clock = ~clock;

  matrix_column_scanner_if #(.COLS(5)) bus_a ();
  matrix_column_scanner_if #(.COLS(4)) bus_b ();

  matrix_column_scanner #(
    .COLS(5), .DWELL(4), .BLANK(1), .ACTIVE_LOW(0)
  ) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (bus_a)
  );

  matrix_column_scanner #(
    .COLS(4), .DWELL(3), .BLANK(2), .ACTIVE_LOW(1)
  ) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (bus_b)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   pos;
    int   dw;
    int   m_paused;
    int   m_pos;
    int   m_dwell;
    int   act;
    logic en;

    reset_a      = 1'b1;
    reset_b      = 1'b1;
    bus_a.enable = 1'b0;
    bus_b.enable = 1'b0;
    repeat (3) step();
    chk("rst_onehot", bus_a.col_onehot, 0);
    chk("rst_group", bus_a.col_group, 0);
    chk("rst_index", bus_a.col_index, 0);
    chk("rst_row_load", bus_a.row_load, 0);
    chk("rst_frame_start", bus_a.frame_start, 0);

    // Free run: 51 cycles ends at pos=2, dwell=2.
    reset_a      = 1'b0;
    bus_a.enable = 1'b1;
    for (int k = 0; k < 51; k++) begin
      step();
      pos = (k / 4) % 5;
      dw  = k % 4;
      chk("run_row_load", bus_a.row_load, (dw == 0));
      chk("run_frame_start", bus_a.frame_start, (dw == 0 && pos == 0));
      chk("run_index", bus_a.col_index, pos);
      chk("run_onehot", bus_a.col_onehot, (dw >= 1) ? oh_a[pos] : 0);
      chk("run_group", bus_a.col_group, (dw >= 1) ? grp_a[pos] : 0);
    end

    bus_a.enable = 1'b0;
    repeat (5) begin
      step();
      chk("pause_onehot", bus_a.col_onehot, 0);
      chk("pause_group", bus_a.col_group, 0);
      chk("pause_row_load", bus_a.row_load, 0);
      chk("pause_index", bus_a.col_index, 2);
    end

    bus_a.enable = 1'b1;
    step();
    chk("resume_row_load", bus_a.row_load, 1);
    chk("resume_index", bus_a.col_index, 2);
    chk("resume_blank", bus_a.col_onehot, 0);
    chk("resume_frame_start", bus_a.frame_start, 0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("resume_onehot", bus_a.col_onehot, 4);
      chk("resume_no_load", bus_a.row_load, 0);
    end
    step();
    chk("next_col_load", bus_a.row_load, 1);
    chk("next_col_index", bus_a.col_index, 3);
    repeat (3) step();
    chk("pos3_dwell3_onehot", bus_a.col_onehot, 8);

    reset_a = 1'b1;
    step();
    chk("midrst_onehot", bus_a.col_onehot, 0);
    chk("midrst_group", bus_a.col_group, 0);
    chk("midrst_index", bus_a.col_index, 0);
    chk("midrst_row_load", bus_a.row_load, 0);
    chk("midrst_frame_start", bus_a.frame_start, 0);
    reset_a = 1'b0;
    step();
    chk("postrst_row_load", bus_a.row_load, 1);
    chk("postrst_frame_start", bus_a.frame_start, 1);
    chk("postrst_index", bus_a.col_index, 0);
    chk("postrst_onehot", bus_a.col_onehot, 0);

    // Random enable toggling against a behavioural model of pos/dwell/paused.
    m_paused = 0;
    m_pos    = 0;
    m_dwell  = 0;
    act      = 0;
    for (int k = 0; k < 10000; k++) begin
      en           = ($urandom_range(0, 3) != 0);
      bus_a.enable = en;
      step();
      if (m_paused != 0) begin
        if (en) begin
          m_paused = 0;
          m_dwell  = 0;
          act      = 0;
        end
      end else if (!en) begin
        m_paused = 1;
      end else if (m_dwell == 3) begin
        chk("rand_active_per_col", act, 3);
        act     = 0;
        m_dwell = 0;
        m_pos   = (m_pos == 4) ? 0 : m_pos + 1;
      end else begin
        m_dwell++;
      end
      chk("rand_row_load", bus_a.row_load, (m_paused == 0 && m_dwell == 0));
      chk("rand_index", bus_a.col_index, m_pos);
      chk("rand_onehot", bus_a.col_onehot,
          (m_paused == 0 && m_dwell >= 1) ? oh_a[m_pos] : 0);
      if (bus_a.col_onehot != 0) act++;
    end

    // Second configuration: COLS=4, DWELL=3, BLANK=2, active-low pins.
    chk("b_rst_onehot", bus_b.col_onehot, 15);
    chk("b_rst_group", bus_b.col_group, 3);
    chk("b_rst_row_load", bus_b.row_load, 0);
    chk("b_rst_index", bus_b.col_index, 0);
    reset_b      = 1'b0;
    bus_b.enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      pos = (k / 3) % 4;
      dw  = k % 3;
      chk("b_onehot", bus_b.col_onehot, (dw == 2) ? oh_b[pos] : 15);
      chk("b_group", bus_b.col_group, (dw == 2) ? grp_b[pos] : 3);
      chk("b_row_load", bus_b.row_load, (dw == 0));
      chk("b_frame_start", bus_b.frame_start, (k % 12 == 0));
      chk("b_index", bus_b.col_index, pos);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
